imm_extend_stage: RTL and testbench

Parametrised, pipelined immediate-extension stage between instruction decode and execute. Takes an IMM_W-bit immediate, a mode select and the decode-stage PC, and produces the extended operand and branch target one cycle later. Adds four extension modes, branch-target arithmetic, valid/ready flow control with a two-entry skid buffer, and a synchronous flush.

---
 rtl/imm_ext_pkg.sv | 15 +
 rtl/imm_ext_core.sv | 53 +++++
 rtl/imm_extend_stage.sv | 120 ++++++++++++
 tb/tb_imm_extend_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encoding and
// the fixed PC increment used when forming branch targets.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_e;

  // Branch targets are relative to the instruction following the branch.
  localparam int unsigned BR_PC_INC = 4;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender and branch-target adder.
// Optional: IMM_EXT_OVF_DETECT_EN adds unsigned wrap detection on the target.
// Requires ad_size >= IMM_W + 2 so the shifted branch offset keeps its sign.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned ad_size = 32,
  parameter int unsigned IMM_W   = 16
) (
  input  logic [IMM_W-1:0]   imm,
  input  imm_mode_e          mode,
  input  logic [ad_size-1:0] pc,
  output logic [ad_size-1:0] ext,
  output logic [ad_size-1:0] target,
  output logic               ovf
);

  localparam int unsigned PadW = ad_size - IMM_W;

  logic [ad_size-1:0] sext;
  logic [ad_size-1:0] offset;

  assign sext   = {{PadW{imm[IMM_W-1]}}, imm};
  assign offset = sext << 2;

  // Select the extended operand; only branch mode alters the passed-through PC.
  always_comb begin
    ext    = '0;
    target = pc;
    unique case (mode)
      MODE_ZERO:   ext = {{PadW{1'b0}}, imm};
      MODE_SIGN:   ext = sext;
      MODE_UPPER:  ext = {imm, {PadW{1'b0}}};
      MODE_BRANCH: begin
        ext    = offset;
        target = pc + ad_size'(BR_PC_INC) + offset;
      end
      default:     ext = '0;
    endcase
  end

`ifdef IMM_EXT_OVF_DETECT_EN
  // Two guard bits hold the true signed target; any non-zero guard means the
  // target left [0, 2^ad_size).
  logic [ad_size+1:0] wide_sum;

  assign wide_sum = {2'b00, pc} + (ad_size + 2)'(BR_PC_INC) + {{2{offset[ad_size-1]}}, offset};
  assign ovf      = (mode == MODE_BRANCH) && (wide_sum[ad_size+1:ad_size] != 2'b00);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/imm_extend_stage.sv
// Pipelined immediate-extension stage: output register plus one skid register
// with valid/ready flow control and synchronous flush.
// Optional: IMM_EXT_OVF_DETECT_EN registers br_ovf alongside br_pc.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int unsigned ad_size = 32,
  parameter int unsigned IMM_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IMM_W-1:0]   id_imm,
  input  logic [1:0]         id_mode,
  input  logic [ad_size-1:0] id_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ad_size-1:0] se_un_address,
  output logic [ad_size-1:0] br_pc,
  output logic               br_ovf
);

  logic [ad_size-1:0] core_ext, core_target;
  logic               core_ovf;

  logic               out_valid_q, skid_valid_q;
  logic [ad_size-1:0] out_ext_q, out_pc_q, skid_ext_q, skid_pc_q;

  logic out_free, accept, load_out_skid, load_out_in, load_skid;

  imm_ext_core #(
    .ad_size(ad_size),
    .IMM_W  (IMM_W)
  ) u_core (
    .imm   (id_imm),
    .mode  (imm_mode_e'(id_mode)),
    .pc    (id_pc),
    .ext   (core_ext),
    .target(core_target),
    .ovf   (core_ovf)
  );

  // Register-only ready: no path from out_ready.
  assign in_ready = !skid_valid_q;

  // Decide where this cycle's data moves; a pending skid entry always wins the
  // output slot, which is why in_ready is low whenever the skid is occupied.
  always_comb begin
    out_free      = !out_valid_q || out_ready;
    accept        = in_valid && !skid_valid_q;
    load_out_skid = !flush && out_free && skid_valid_q;
    load_out_in   = !flush && out_free && !skid_valid_q && accept;
    load_skid     = !flush && !out_free && accept;
  end

  // Occupancy flags; flush empties both slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_free ? (skid_valid_q || accept) : 1'b1;
      skid_valid_q <= load_skid || (skid_valid_q && !out_free);
    end
  end

  // Output and skid payloads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ext_q  <= '0;
      out_pc_q   <= '0;
      skid_ext_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      if (load_out_skid) begin
        out_ext_q <= skid_ext_q;
        out_pc_q  <= skid_pc_q;
      end else if (load_out_in) begin
        out_ext_q <= core_ext;
        out_pc_q  <= core_target;
      end
      if (load_skid) begin
        skid_ext_q <= core_ext;
        skid_pc_q  <= core_target;
      end
    end
  end

`ifdef IMM_EXT_OVF_DETECT_EN
  logic out_ovf_q, skid_ovf_q;

  // Overflow flag travels with its transaction through both slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ovf_q  <= 1'b0;
      skid_ovf_q <= 1'b0;
    end else begin
      if (load_out_skid)    out_ovf_q <= skid_ovf_q;
      else if (load_out_in) out_ovf_q <= core_ovf;
      if (load_skid)        skid_ovf_q <= core_ovf;
    end
  end

  assign br_ovf = out_ovf_q;
`else
  logic unused_core_ovf;
  assign unused_core_ovf = core_ovf;
  assign br_ovf          = 1'b0;
`endif

  assign out_valid     = out_valid_q;
  assign se_un_address = out_ext_q;
  assign br_pc         = out_pc_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed cases plus randomized
// traffic against a queue-based reference model.
module tb_imm_extend_stage;
  import imm_ext_pkg::*;

  localparam int unsigned AD = 32;
  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, br_ovf;
  logic [IW-1:0] id_imm;
  logic [1:0]    id_mode;
  logic [AD-1:0] id_pc, se_un_address, br_pc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AD-1:0] ext;
    logic [AD-1:0] pc;
    logic          ovf;
  } txn_t;

  txn_t model_q[$];

  always #5 clk = ~clk;

  imm_extend_stage #(
    .ad_size(AD),
    .IMM_W  (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .id_imm       (id_imm),
    .id_mode      (id_mode),
    .id_pc        (id_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .se_un_address(se_un_address),
    .br_pc        (br_pc),
    .br_ovf       (br_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint span;
    span = longint'(1) << AD;
    return ((v % span) + span) % span;
  endfunction

  // Expected result from the arithmetic meaning of each mode.
  function automatic txn_t ref_txn(input logic [1:0] mode, input logic [IW-1:0] imm,
                                   input logic [AD-1:0] pc);
    txn_t   t;
    longint simm, off, target;
    simm = (longint'(imm) >= (longint'(1) << (IW - 1))) ? longint'(imm) - (longint'(1) << IW)
                                                         : longint'(imm);
    t.pc  = pc;
    t.ovf = 1'b0;
    case (mode)
      2'd0: t.ext = AD'(longint'(imm));
      2'd1: t.ext = AD'(wrap(simm));
      2'd2: t.ext = AD'(wrap(longint'(imm) * (longint'(1) << (AD - IW))));
      default: begin
        off    = simm * 4;
        target = longint'(pc) + 4 + off;
        t.ext  = AD'(wrap(off));
        t.pc   = AD'(wrap(target));
`ifdef IMM_EXT_OVF_DETECT_EN
        t.ovf  = (target < 0) || (target >= (longint'(1) << AD));
`endif
      end
    endcase
    return t;
  endfunction

  // One clock: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic cycle(input logic iv, input logic [1:0] md, input logic [IW-1:0] im,
                       input logic [AD-1:0] pc, input logic ordy, input logic fl);
    bit   rdy;
    txn_t t;
    in_valid  = iv;
    id_mode   = md;
    id_imm    = im;
    id_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_eq("out_valid", out_valid, model_q.size() > 0);
    check_eq("in_ready", in_ready, model_q.size() < 2);
    if (model_q.size() > 0) begin
      check_eq("se_un_address", se_un_address, model_q[0].ext);
      check_eq("br_pc", br_pc, model_q[0].pc);
      check_eq("br_ovf", br_ovf, model_q[0].ovf);
    end
    rdy = model_q.size() < 2;
    @(posedge clk);
    if (!rst_n || fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() > 0 && ordy) void'(model_q.pop_front());
      if (iv && rdy) begin
        t = ref_txn(md, im, pc);
        model_q.push_back(t);
      end
    end
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    id_imm    = 16'hFFFF;
    id_mode   = 2'd3;
    id_pc     = 32'h1234;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_se", se_un_address, 32'h0);
    check_eq("rst_br_pc", br_pc, 32'h0);
    check_eq("rst_br_ovf", br_ovf, 1'b0);
    rst_n = 1'b1;

    // Mode literals, one cycle after accept.
    cycle(1'b1, 2'd1, 16'h8000, 32'h1000, 1'b1, 1'b0);
    check_eq("sign_lit", se_un_address, 32'hFFFF8000);
    cycle(1'b1, 2'd0, 16'h8000, 32'h1000, 1'b1, 1'b0);
    check_eq("zero_lit", se_un_address, 32'h00008000);
    cycle(1'b1, 2'd2, 16'h1234, 32'h1000, 1'b1, 1'b0);
    check_eq("upper_lit", se_un_address, 32'h12340000);
    cycle(1'b1, 2'd3, 16'hFFFF, 32'h100, 1'b1, 1'b0);
    check_eq("br_back_se", se_un_address, 32'hFFFFFFFC);
    check_eq("br_back_pc", br_pc, 32'h100);
    cycle(1'b1, 2'd3, 16'h0003, 32'h100, 1'b1, 1'b0);
    check_eq("br_fwd_pc", br_pc, 32'h110);
    check_eq("br_fwd_ovf", br_ovf, 1'b0);
    cycle(1'b1, 2'd3, 16'h0001, 32'hFFFFFFF8, 1'b1, 1'b0);
    check_eq("br_wrap_pc", br_pc, 32'h0);
`ifdef IMM_EXT_OVF_DETECT_EN
    check_eq("br_wrap_ovf", br_ovf, 1'b1);
`else
    check_eq("br_wrap_ovf", br_ovf, 1'b0);
`endif
    cycle(1'b0, 2'd0, 16'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back stream.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'd0, IW'(i + 1), 32'h200, 1'b1, 1'b0);
      check_eq("b2b_valid", out_valid, 1'b1);
    end
    cycle(1'b0, 2'd0, 16'h0, 32'h0, 1'b1, 1'b0);

    // Stall fills output then skid, then drains in order.
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd1, IW'(16'h7FF0 + i), 32'h300, 1'b0, 1'b0);
    check_eq("full_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 16'h0, 32'h0, 1'b1, 1'b0);
    check_eq("drained_in_ready", in_ready, 1'b1);

    // Flush with skid full; flush-cycle input is discarded.
    cycle(1'b1, 2'd0, 16'h00AA, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 16'h00BB, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 16'h00CC, 32'h400, 1'b0, 1'b1);
    check_eq("flush_out_valid", out_valid, 1'b0);
    check_eq("flush_in_ready", in_ready, 1'b1);
    cycle(1'b0, 2'd0, 16'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(99) != 0);
      cycle(($urandom_range(9) < 7), 2'($urandom_range(3)), IW'($urandom),
            ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : 32'($urandom),
            ($urandom_range(9) < 6), ($urandom_range(32) == 0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 16'h0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
